// File: rtl/frame_sched_pkg.sv
// Shared state encoding, default widths and address packing for the frame scheduler.
package frame_sched_pkg;

    localparam int COL_W   = 7;
    localparam int ROW_W   = 6;
    localparam int COLOR_W = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        REQ    = 3'd2,
        WRITE  = 3'd3,
        UPDATE = 3'd4
    } state_t;

    // pixelRAM address layout: column in the upper bits, row in the lower bits.
    function automatic logic [COL_W+ROW_W-1:0] pack_addr(input logic [COL_W-1:0] col,
                                                         input logic [ROW_W-1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/frame_scheduler_raster_addr_gen.sv
// Raster-order block address counter with clear, advance and last-block flag.
// Row step becomes 2 (one field per frame) when INTERLACE_EN is defined.
module raster_addr_gen #(
    parameter int COL_W = 7,
    parameter int ROW_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
`ifdef INTERLACE_EN
    input  logic             phase,
`endif
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);
    import frame_sched_pkg::*;

`ifdef INTERLACE_EN
    localparam int ROW_STEP = 2;
    logic [ROW_W-1:0] row_first;
    assign row_first = {{(ROW_W-1){1'b0}}, phase};
`else
    localparam int ROW_STEP = 1;
    logic [ROW_W-1:0] row_first;
    assign row_first = '0;
`endif

    // With a step of 2 the final row is 62 or 63 depending on the field.
    localparam logic [ROW_W-1:0] ROW_LAST_MIN = {ROW_W{1'b1}} - ROW_W'(ROW_STEP - 1);

    assign last = (&col) && (row >= ROW_LAST_MIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= row_first;
        end else if (adv) begin
            col <= col + 1'b1;
            if (&col) begin
                row <= row + ROW_W'(ROW_STEP);
            end
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: walks the block grid, hands blocks to the tracer, writes pixelRAM,
// and opens a bounded scene-update window between frames. Option macro: INTERLACE_EN.
module frame_scheduler #(
    parameter int COL_W       = 7,
    parameter int ROW_W       = 6,
    parameter int COLOR_W     = 12,
    parameter int UPD_TIMEOUT = 1024,
    parameter int FCNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   trace_req,
    output logic [COL_W-1:0]       trace_col,
    output logic [ROW_W-1:0]       trace_row,
    input  logic                   trace_ack,
    input  logic [COLOR_W-1:0]     trace_color,
    output logic                   wr_en,
    output logic [COL_W+ROW_W-1:0] wr_addr,
    output logic [COLOR_W-1:0]     wr_data,
    output logic                   upd_grant,
    input  logic                   upd_done,
    output logic                   scene_latch,
    output logic                   frame_done,
    output logic [FCNT_W-1:0]      frame_count,
    output logic                   busy
);
    import frame_sched_pkg::*;

    localparam int UCNT_W = (UPD_TIMEOUT > 1) ? $clog2(UPD_TIMEOUT) : 1;
    localparam logic [UCNT_W-1:0] UPD_LAST = UCNT_W'(UPD_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              mid_frame;
    logic [UCNT_W-1:0] upd_cnt;
    logic              addr_clr;
    logic              addr_adv;
    logic              addr_last;
    logic              upd_exit;

    assign trace_req   = (state == REQ);
    assign wr_en       = (state == WRITE);
    assign upd_grant   = (state == UPDATE);
    assign scene_latch = (state == LATCH);
    assign busy        = (state != IDLE);

    assign addr_clr = (state == LATCH);
    assign addr_adv = (state == WRITE);
    // A host done and a timeout landing together collapse into one exit.
    assign upd_exit = upd_done || (upd_cnt == UPD_LAST);

    raster_addr_gen #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_addr (
        .clk   (clk),
        .rst   (rst),
        .clr   (addr_clr),
        .adv   (addr_adv),
`ifdef INTERLACE_EN
        .phase (frame_count[0]),
`endif
        .col   (trace_col),
        .row   (trace_row),
        .last  (addr_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = mid_frame ? REQ : LATCH;
            LATCH:   state_nxt = REQ;
            REQ:     if (trace_ack) state_nxt = WRITE;
            WRITE: begin
                if (addr_last) state_nxt = UPDATE;
                else           state_nxt = run ? REQ : IDLE;
            end
            UPDATE:  if (upd_exit) state_nxt = run ? LATCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mid_frame   <= 1'b0;
            upd_cnt     <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            case (state)
                REQ: begin
                    if (trace_ack) begin
                        wr_addr <= pack_addr(trace_col, trace_row);
                        wr_data <= trace_color;
                    end
                end
                WRITE: begin
                    mid_frame <= !addr_last;
                    if (addr_last) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end
                end
                UPDATE: upd_cnt <= upd_exit ? '0 : upd_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences the ray tracer across the 128x64 pixel-block grid and owns pixelRAM write timing.
- Walks addresses in raster order and hands each block to the tracer with a req/ack handshake. Writes the returned colour into pixelRAM.
- Between frames, grants the object host a bounded scene-update window, so objects never change mid-frame.

Parameters:
- COL_W, 7, column address width (128 columns).
- ROW_W, 6, row address width (64 rows).
- COLOR_W, 12, pixel colour width (4:4:4).
- UPD_TIMEOUT, 1024, maximum cycles the update window stays open.
- FCNT_W, 16, frame counter width.

Ports:
- clk  in  1  scheduler clock (same domain as tracer and pixelRAM write port).
- rst  in  1  asynchronous, active-high reset.
- run  in  1  enable. Sampled at pixel boundaries and in IDLE.
- trace_req  out  1  request to trace the block at trace_col/trace_row.
- trace_col  out  COL_W  column of the requested block.
- trace_row  out  ROW_W  row of the requested block.
- trace_ack  in  1  tracer result valid.
- trace_color  in  COLOR_W  tracer result, valid with trace_ack.
- wr_en  out  1  pixelRAM write strobe.
- wr_addr  out  COL_W+ROW_W  pixelRAM address, packed {col,row}.
- wr_data  out  COLOR_W  pixelRAM write data.
- upd_grant  out  1  object host may update the scene.
- upd_done  in  1  object host finished its update.
- scene_latch  out  1  one-cycle pulse: tracer snapshots the object bus.
- frame_done  out  1  one-cycle pulse after the last write of a frame.
- frame_count  out  FCNT_W  completed frames. Wraps modulo 2^FCNT_W.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, address (0,0), mid_frame=0, timeout counter 0.
- IDLE: if run=1, next state is REQ when mid_frame=1, otherwise LATCH.
- LATCH (1 cycle): scene_latch=1. Address is set to the first block of the frame. Next state is REQ.
- REQ:
  - trace_req=1. trace_col/trace_row stay stable until ack.
  - A trace_ack sampled high in REQ (same cycle as req is allowed) captures trace_color. Next state is WRITE.
  - trace_ack outside REQ is ignored.
- WRITE (1 cycle):
  - wr_en=1, wr_addr={col,row}, wr_data=the captured colour.
  - Address advance: col+1. At col=127, col wraps to 0 and row+1.
  - If the written block was (127,63): frame_done=1 and frame_count+1 in this cycle, mid_frame=0, next state UPDATE.
  - Otherwise mid_frame=1. Next state is REQ if run=1, else IDLE (pause; address retained).
- UPDATE:
  - upd_grant=1. The timeout counter increments each cycle.
  - upd_done=1, or counter=UPD_TIMEOUT-1, ends the window. The counter clears.
  - Next state is LATCH if run=1, else IDLE.
  - upd_done and timeout in the same cycle: treated as a single exit.
- Timing: minimum 2 cycles per pixel (REQ with immediate ack, then WRITE). Full frame = 8192 pixels = 16384 cycles plus the UPDATE and LATCH overhead.
- Outputs are registered except trace_req, wr_en, upd_grant, scene_latch and busy, which decode directly from state.
- Reset mid-frame: any partial frame is abandoned and frame_count clears. Tracer-side state is not the scheduler's concern.

Optional Feature:
- INTERLACE_EN defined:
  - Each frame traces only rows whose parity equals frame_count[0] at LATCH.
  - Row advances by 2. The frame ends at (127,62) for even frames and (127,63) for odd frames. 4096 pixels per frame.
- INTERLACE_EN undefined: all 64 rows, as specified above.

Decomposition:
- Package frame_sched_pkg: state enum (IDLE, LATCH, REQ, WRITE, UPDATE), COL_W/ROW_W/COLOR_W constants, and a pack_addr function giving {col,row}.
- Sub-module raster_addr_gen: col/row counter with clear, advance and last-block flag. Row step is 1 or 2 under INTERLACE_EN.

Test Plan:
- Reset, then run=0 for 10 cycles -> all outputs 0, busy=0, frame_count=0.
- run=1, ack delayed 3 cycles with colour 0xABC -> scene_latch pulse, trace_req held 4 cycles at (0,0), then wr_en with wr_addr=0x0000 and wr_data=0xABC.
- Immediate ack through block (127,0) -> next request is (1,... no: next request is col=0, row=1; that write has wr_addr=13'h0001.
- Full frame with immediate ack and upd_done=0 -> frame_done 16384 cycles after the first REQ. upd_grant stays high 1024 cycles, then scene_latch, frame_count=1.
- Drop run during a REQ at (5,2) -> that pixel completes, IDLE holds the address. run=1 resumes at (6,2) with no scene_latch.
- Assert rst during UPDATE -> next cycle all outputs 0. After release, run=1 restarts at (0,0) with a scene_latch pulse.
